// File: rtl/tpu_host_bridge_if.sv
// rtl/tpu_host_bridge_if.sv - host request/response bus for the TPU host bridge
interface tpu_host_bridge_if #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16
);
    logic             req_valid;
    logic             req_ready;
    logic             req_wr;
    logic [ADDRW-1:0] req_addr;
    logic [DATAW-1:0] req_data;
    logic             rsp_valid;
    logic [DATAW-1:0] rsp_data;
    logic             rsp_err;
    logic             busy;

    // host side: issues requests, observes responses
    modport master (
        output req_valid, req_wr, req_addr, req_data,
        input  req_ready, rsp_valid, rsp_data, rsp_err, busy
    );

    // bridge side
    modport slave (
        input  req_valid, req_wr, req_addr, req_data,
        output req_ready, rsp_valid, rsp_data, rsp_err, busy
    );
endinterface

// File: rtl/tpu_host_bridge.sv
// rtl/tpu_host_bridge.sv - host request to TPU single-cycle access bridge (optional TPU_BRIDGE_ADDRCHK_EN)
module tpu_host_bridge #(
    parameter int DATAW = 64,
    parameter int ADDRW = 16,
    parameter int DIM   = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    tpu_host_bridge_if.slave host,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] ISSUE     = 2'd1;
    localparam logic [1:0] MULT_WAIT = 2'd2;
    localparam logic [1:0] RESP      = 2'd3;

    localparam int MULT_CYCLES = 3 * DIM - 2;
    localparam int CNTW        = (MULT_CYCLES < 2) ? 1 : $clog2(MULT_CYCLES + 1);

    localparam logic [ADDRW-1:0] START_ADDR = ADDRW'(16'h0400);

    logic [1:0]       state;
    logic [CNTW-1:0]  cnt;
    logic             wr_q;
    logic             ok_q;
    logic [DATAW-1:0] rsp_data_q;
    logic             addr_ok;

`ifdef TPU_BRIDGE_ADDRCHK_EN
    // Only the documented TPU windows are reachable; reads only from the result window.
    always_comb begin
        addr_ok = 1'b0;
        if (host.req_wr) begin
            if ((host.req_addr >= ADDRW'(16'h0100) && host.req_addr <= ADDRW'(16'h013F)) ||
                (host.req_addr >= ADDRW'(16'h0200) && host.req_addr <= ADDRW'(16'h023F)) ||
                (host.req_addr >= ADDRW'(16'h0300) && host.req_addr <= ADDRW'(16'h037F)) ||
                (host.req_addr == START_ADDR))
                addr_ok = 1'b1;
        end else begin
            if (host.req_addr >= ADDRW'(16'h0300) && host.req_addr <= ADDRW'(16'h037F))
                addr_ok = 1'b1;
        end
    end

    assign host.rsp_err = (state == RESP) && !ok_q;
`else
    assign addr_ok      = 1'b1;
    assign host.rsp_err = 1'b0;
`endif

    // Request capture, TPU access, multiply hold-off and response sequencing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            wr_q       <= 1'b0;
            ok_q       <= 1'b0;
            tpu_addr   <= '0;
            tpu_dataIn <= '0;
            rsp_data_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (host.req_valid) begin
                        wr_q       <= host.req_wr;
                        ok_q       <= addr_ok;
                        tpu_addr   <= host.req_addr;
                        tpu_dataIn <= host.req_data;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    // tpu_dataOut is combinational from tpu_addr, so it is valid here.
                    rsp_data_q <= (!wr_q && ok_q) ? tpu_dataOut : '0;
                    if (wr_q && ok_q && tpu_addr == START_ADDR) begin
                        cnt   <= CNTW'(MULT_CYCLES);
                        state <= MULT_WAIT;
                    end else begin
                        state <= RESP;
                    end
                end
                MULT_WAIT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CNTW'(1))
                        state <= RESP;
                end
                RESP: begin
                    rsp_data_q <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status and strobes decode straight from state so reset clears them at once.
    always_comb begin
        tpu_r_w        = (state == ISSUE) && wr_q && ok_q;
        host.req_ready = (state == IDLE);
        host.busy      = (state != IDLE);
        host.rsp_valid = (state == RESP);
        host.rsp_data  = rsp_data_q;
    end

endmodule

// File: tb/tb_tpu_host_bridge.sv
// tb/tb_tpu_host_bridge.sv - self-checking bench for tpu_host_bridge
`timescale 1ns/1ps
module tb_tpu_host_bridge;

    localparam int DATAW = 64;
    localparam int ADDRW = 16;
    localparam int DIM   = 8;

    logic             clk;
    logic             rst_n;
    logic             tpu_r_w;
    logic [ADDRW-1:0] tpu_addr;
    logic [DATAW-1:0] tpu_dataIn;
    logic [DATAW-1:0] tpu_dataOut;

    int checks   = 0;
    int failures = 0;

    tpu_host_bridge_if #(.DATAW(DATAW), .ADDRW(ADDRW)) hif ();

    tpu_host_bridge #(.DATAW(DATAW), .ADDRW(ADDRW), .DIM(DIM)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .host        (hif.slave),
        .tpu_r_w     (tpu_r_w),
        .tpu_addr    (tpu_addr),
        .tpu_dataIn  (tpu_dataIn),
        .tpu_dataOut (tpu_dataOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [63:0] data;
        logic [63:0] dout;
        logic        legal;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Present one request in the current IDLE cycle; returns in the ISSUE cycle (+1ns).
    task automatic send(input logic wr, input logic [15:0] addr, input logic [63:0] data);
        hif.req_valid = 1'b1;
        hif.req_wr    = wr;
        hif.req_addr  = addr;
        hif.req_data  = data;
        @(posedge clk);
        #1;
        hif.req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        ok;
        logic [63:0] exp_data;
        int acc_k [3];
        int rsp_k [3];
        int n_acc;
        int n_rsp;
        int busy_cnt;
        int ready_cnt;
        int rsp_at;

        vecs[0] = '{1'b1, 16'h0100, 64'h0102030405060708, 64'h0,                1'b1};
        vecs[1] = '{1'b0, 16'h0308, 64'h0,                64'hDEADBEEFCAFEF00D, 1'b1};
        vecs[2] = '{1'b1, 16'h0150, 64'h5555AAAA5555AAAA, 64'h0,                1'b0};
        vecs[3] = '{1'b0, 16'h037F, 64'h0,                64'h1122334455667788, 1'b1};
        vecs[4] = '{1'b0, 16'h0100, 64'h0,                64'h0F0E0D0C0B0A0908, 1'b0};
        vecs[5] = '{1'b1, 16'h023F, 64'hFFFF0000FFFF0000, 64'h0,                1'b1};
        vecs[6] = '{1'b1, 16'h0380, 64'h1234567812345678, 64'h0,                1'b0};

        rst_n         = 1'b0;
        hif.req_valid = 1'b0;
        hif.req_wr    = 1'b0;
        hif.req_addr  = '0;
        hif.req_data  = '0;
        tpu_dataOut   = 64'h0;

        #12;
        chk("reset_busy",      64'(hif.busy),      64'd0);
        chk("reset_rsp_valid", 64'(hif.rsp_valid), 64'd0);
        chk("reset_rsp_data",  hif.rsp_data,       64'd0);
        chk("reset_rsp_err",   64'(hif.rsp_err),   64'd0);
        chk("reset_tpu_r_w",   64'(tpu_r_w),       64'd0);
        chk("reset_tpu_addr",  64'(tpu_addr),      64'd0);
        chk("reset_tpu_din",   tpu_dataIn,         64'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_ready", 64'(hif.req_ready), 64'd1);
        @(posedge clk);
        #1;

        // table-driven single accesses
        for (int i = 0; i < 7; i++) begin
`ifdef TPU_BRIDGE_ADDRCHK_EN
            ok = vecs[i].legal;
`else
            ok = 1'b1;
`endif
            exp_data = (!vecs[i].wr && ok) ? vecs[i].dout : 64'h0;
            tpu_dataOut = vecs[i].dout;
            send(vecs[i].wr, vecs[i].addr, vecs[i].data);
            @(negedge clk);
            chk($sformatf("v%0d_issue_r_w", i),   64'(tpu_r_w),       64'(vecs[i].wr & ok));
            chk($sformatf("v%0d_issue_addr", i),  64'(tpu_addr),      64'(vecs[i].addr));
            chk($sformatf("v%0d_issue_din", i),   tpu_dataIn,         vecs[i].wr ? vecs[i].data : 64'h0);
            chk($sformatf("v%0d_issue_busy", i),  64'(hif.busy),      64'd1);
            chk($sformatf("v%0d_issue_ready", i), 64'(hif.req_ready), 64'd0);
            chk($sformatf("v%0d_issue_rsp", i),   64'(hif.rsp_valid), 64'd0);
            @(posedge clk);
            #1 tpu_dataOut = 64'hBADBADBADBADBAD0;
            @(negedge clk);
            chk($sformatf("v%0d_resp_valid", i), 64'(hif.rsp_valid), 64'd1);
            chk($sformatf("v%0d_resp_data", i),  hif.rsp_data,       exp_data);
            chk($sformatf("v%0d_resp_err", i),   64'(hif.rsp_err),   64'(!ok));
            chk($sformatf("v%0d_resp_r_w", i),   64'(tpu_r_w),       64'd0);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_idle_rsp", i),   64'(hif.rsp_valid), 64'd0);
            chk($sformatf("v%0d_idle_ready", i), 64'(hif.req_ready), 64'd1);
        end

        // multiply start: busy and ready for N+1..N+24, one response at N+24
        send(1'b1, 16'h0400, 64'h1);
        busy_cnt = 0; ready_cnt = 0; n_rsp = 0; rsp_at = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (hif.busy) busy_cnt++;
            if (hif.req_ready && k <= 3 * DIM) ready_cnt++;
            if (hif.rsp_valid) begin
                n_rsp++;
                rsp_at = k;
            end
        end
        chk("mult_busy_cycles", 64'(busy_cnt),  64'd24);
        chk("mult_ready_low",   64'(ready_cnt), 64'd0);
        chk("mult_rsp_count",   64'(n_rsp),     64'd1);
        chk("mult_rsp_cycle",   64'(rsp_at),    64'd24);
        @(posedge clk);
        #1;

        // back-to-back reads with valid held continuously
        tpu_dataOut   = 64'hA5A5A5A55A5A5A5A;
        hif.req_valid = 1'b1;
        hif.req_wr    = 1'b0;
        hif.req_addr  = 16'h0300;
        n_acc = 0; n_rsp = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (hif.req_valid && hif.req_ready && n_acc < 3) begin
                acc_k[n_acc] = k;
                n_acc++;
            end
            if (hif.rsp_valid && n_rsp < 3) begin
                rsp_k[n_rsp] = k;
                n_rsp++;
                chk("b2b_rsp_data", hif.rsp_data, 64'hA5A5A5A55A5A5A5A);
            end
            @(posedge clk);
            #1;
            if (n_acc == 3) hif.req_valid = 1'b0;
        end
        chk("b2b_acc_count", 64'(n_acc), 64'd3);
        chk("b2b_rsp_count", 64'(n_rsp), 64'd3);
        if (n_acc == 3 && n_rsp == 3) begin
            for (int j = 0; j < 3; j++) begin
                chk($sformatf("b2b_acc%0d", j), 64'(acc_k[j]), 64'(3 * j));
                chk($sformatf("b2b_rsp%0d", j), 64'(rsp_k[j]), 64'(3 * j + 2));
            end
        end

        // reset in the middle of a multiply
        send(1'b1, 16'h0400, 64'h77);
        repeat (9) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_busy",      64'(hif.busy),      64'd0);
        chk("mrst_rsp_valid", 64'(hif.rsp_valid), 64'd0);
        chk("mrst_tpu_r_w",   64'(tpu_r_w),       64'd0);
        chk("mrst_tpu_addr",  64'(tpu_addr),      64'd0);
        chk("mrst_tpu_din",   tpu_dataIn,         64'd0);
        chk("mrst_rsp_data",  hif.rsp_data,       64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("mrst_ready_after", 64'(hif.req_ready), 64'd1);
        n_rsp = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (hif.rsp_valid || hif.busy) n_rsp++;
        end
        chk("mrst_no_activity", 64'(n_rsp), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
